crossing_scheduler: RTL and testbench
=====================================

CROSSING_SCHEDULER -- requirements
Module: crossing_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, number of pedestrian crosswalk requesters (2..8).
REQ-002 Parameter MIN_GAP, default 8, cycles of guaranteed road-green between two crossings (>=1).
REQ-003 Parameter TIMEOUT, default 64, max cycles waiting for sequencer completion (>=2).
REQ-004 clk  input  1  single clock; all state on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-crosswalk button pulses; bit i high for one or more cycles = request i.
REQ-007 seq_ok  input  1  crossing sequencer done indication, sampled in WAIT only.
REQ-008 seq_trg  output  1  one-cycle start pulse to the shared crossing sequencer.
REQ-009 sel  output  $clog2(N_REQ)  index of crosswalk currently granted; held stable from ISSUE through WAIT.
REQ-010 pending  output  N_REQ  latched, not-yet-served requests.
REQ-011 busy  output  1  high in ISSUE, WAIT, GAP.
REQ-012 err  output  1  sticky timeout flag.

Function
REQ-013 States IDLE, ISSUE, WAIT, GAP; registered state, combinational next-state.
REQ-014 pending[i] sets on any cycle req[i]=1; repeated requests on a set bit merge (no count).
REQ-015 IDLE: pending==0 -> stay; else -> ISSUE next cycle.
REQ-016 ISSUE (exactly one cycle): seq_trg=1, sel=round-robin winner, winner's pending bit cleared, last_sel<=winner, -> WAIT.
REQ-017 Round-robin: search pending from last_sel+1 upward, wrapping at N_REQ-1 to 0; first set bit wins.
REQ-018 req[i]=1 in the same cycle pending[i] is cleared by ISSUE: set wins, bit stays 1 (new request).
REQ-019 WAIT: seq_ok=1 -> GAP, gap counter loaded with MIN_GAP-1; seq_trg=0 throughout.
REQ-020 GAP: counter decrements each cycle; at 0 -> IDLE; new requests still latched, none issued.
REQ-021 Latency: pending set in cycle t with scheduler idle -> seq_trg in cycle t+2.
REQ-022 Minimum spacing: seq_ok cycle to next seq_trg >= MIN_GAP+2 cycles.
REQ-023 seq_ok outside WAIT ignored; seq_ok in the ISSUE cycle ignored.
REQ-024 Counters sized $clog2(max(MIN_GAP,TIMEOUT))+1 bits; no wrap in operation.

Reset
REQ-025 reset low: state=IDLE, pending=0, seq_trg=0, sel=0, busy=0, err=0, last_sel=N_REQ-1 (first grant favours index 0), counters=0.
REQ-026 Reset mid-crossing abandons the grant; no seq_trg until requests re-arrive after release.
REQ-027 Outputs valid the first clock edge after reset deasserts; req sampled from that edge.

Configuration
REQ-028 Macro CROSS_TIMEOUT_EN defined: WAIT counts cycles; at TIMEOUT cycles without seq_ok, err<=1 (sticky until reset), -> GAP as if seq_ok.
REQ-029 Macro undefined: no timeout counter, WAIT waits indefinitely, err tied 0.

Structure
REQ-030 Package crossing_pkg holds the state enum typedef, default constants for N_REQ/MIN_GAP/TIMEOUT.
REQ-031 Sub-module rr_arbiter (pending, last_sel in; winner index, valid out, purely combinational) instantiated once.

Verification
REQ-032 After reset, req=4'b0001 one cycle -> seq_trg at +2 cycles, sel=0, pending=0, busy=1.
REQ-033 req=4'b1111 together, seq_ok 3 cycles after each trg -> grants sel 0,1,2,3 in order, each separated by >=10 cycles ok-to-trg.
REQ-034 Grant sel=1, then req=4'b0011 during WAIT -> next grant sel=0 (wrap after 1 served? no: search 2,3,0) -> sel=0, then sel=1.
REQ-035 req[2] pulsed in its own ISSUE cycle -> pending[2] remains 1, served again after GAP.
REQ-036 CROSS_TIMEOUT_EN, no seq_ok for 64 cycles -> err=1, state GAP, next pending served; undefined build -> state stays WAIT, err=0.
REQ-037 reset asserted in WAIT with pending=4'b0110 -> immediately IDLE, pending=0, seq_trg never pulses until new req.

Source files
------------

// File: rtl/crossing_pkg.sv
// crossing_pkg: shared state encoding, default sizing and counter-width helper
// for the crosswalk crossing scheduler.
package crossing_pkg;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_MIN_GAP = 8;
    localparam int DEF_TIMEOUT = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // One extra bit over the larger count so a counter never wraps in operation.
    function automatic int cnt_width(input int min_gap, input int timeout);
        return $clog2((min_gap > timeout) ? min_gap : timeout) + 1;
    endfunction

endpackage

// File: rtl/crossing_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick over the pending crosswalks,
// searching upward from the slot after last_sel and wrapping at N_REQ-1.
module rr_arbiter #(
    parameter int N_REQ = crossing_pkg::DEF_N_REQ
) (
    input  logic [N_REQ-1:0]         pending,
    input  logic [$clog2(N_REQ)-1:0] last_sel,
    output logic [$clog2(N_REQ)-1:0] winner,
    output logic                     valid
);

    localparam int SW = $clog2(N_REQ);

    logic [SW-1:0] cand [N_REQ];

    // cand[k] is the index visited (k+1) steps after last_sel.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
        assign cand[gi] = SW'((int'(last_sel) + gi + 1) % N_REQ);
    end

    // Scanning from the farthest candidate lets the nearest set bit win last.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (pending[cand[k]]) begin
                winner = cand[k];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/crossing_scheduler.sv
// crossing_scheduler: round-robin grant of one shared crossing sequencer to N_REQ crosswalks.
// Define CROSS_TIMEOUT_EN to bound WAIT by TIMEOUT cycles and raise the sticky err flag.
module crossing_scheduler
    import crossing_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int MIN_GAP = DEF_MIN_GAP,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic                     seq_ok,
    output logic                     seq_trg,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic [N_REQ-1:0]         pending,
    output logic                     busy,
    output logic                     err
);

    localparam int SW = $clog2(N_REQ);
    localparam int CW = cnt_width(MIN_GAP, TIMEOUT);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    state_t           state_reg, state_next;
    logic [N_REQ-1:0] pending_reg;
    logic [SW-1:0]    sel_reg, last_sel_reg, winner;
    logic             win_valid;
    logic [CW-1:0]    gap_cnt_reg;
    logic             timeout_hit;
    logic [N_REQ-1:0] grant_mask;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .pending (pending_reg),
        .last_sel(last_sel_reg),
        .winner  (winner),
        .valid   (win_valid)
    );

`ifdef CROSS_TIMEOUT_EN
    logic [CW-1:0] wait_cnt_reg;
    logic          err_reg;

    assign timeout_hit = (state_reg == WAIT) && !seq_ok && (wait_cnt_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 1'b1 : '0;
            if (timeout_hit) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign err = err_reg;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // The winner's bit is cleared on the edge entering ISSUE; a same-cycle req re-sets it.
    assign grant_mask = (state_reg == IDLE && win_valid) ? (ONE << winner) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        seq_trg    = 1'b0;
        busy       = 1'b1;
        unique case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (win_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                seq_trg    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (seq_ok || timeout_hit) begin
                    state_next = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_reg == '0) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_reg  <= '0;
            sel_reg      <= '0;
            last_sel_reg <= SW'(N_REQ - 1);
            gap_cnt_reg  <= '0;
        end else begin
            pending_reg <= (pending_reg & ~grant_mask) | req;
            if (state_reg == IDLE && win_valid) begin
                sel_reg      <= winner;
                last_sel_reg <= winner;
            end
            if (state_reg == WAIT && state_next == GAP) begin
                gap_cnt_reg <= CW'(MIN_GAP - 1);
            end else if (state_reg == GAP && gap_cnt_reg != '0) begin
                gap_cnt_reg <= gap_cnt_reg - 1'b1;
            end
        end
    end

    assign sel     = sel_reg;
    assign pending = pending_reg;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Testbench for crossing_scheduler: directed scenario tasks plus a randomized run
// against a timestamp-based reference model of the scheduling rules.
module tb_crossing_scheduler;

    localparam int N       = 4;
    localparam int MIN_GAP = 8;
    localparam int TIMEOUT = 64;
    localparam int SW      = $clog2(N);
    localparam int TR      = 2048;

    logic          clk    = 1'b0;
    logic          reset  = 1'b0;
    logic [N-1:0]  req    = '0;
    logic          seq_ok = 1'b0;
    logic          seq_trg;
    logic [SW-1:0] sel;
    logic [N-1:0]  pending;
    logic          busy;
    logic          err;

    crossing_scheduler #(.N_REQ(N), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .seq_ok (seq_ok),
        .seq_trg(seq_trg),
        .sel    (sel),
        .pending(pending),
        .busy   (busy),
        .err    (err)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: a grant is described by its issue cycle and completion cycle.
    int           n, issue_at, ok_at, m_last, m_sel, n0;
    bit           active, m_err;
    logic [N-1:0] m_pend;
    logic         e_trg, e_busy, e_err;
    logic [N-1:0] e_pend;
    logic [SW-1:0] e_sel;

    logic         obs_trg [TR];
    logic         obs_busy[TR];
    logic         obs_err [TR];
    logic [N-1:0] obs_pend[TR];
    int g_sel[$];
    int g_cyc[$];
    int g_ok[$];

    function automatic int rr_pick(input logic [N-1:0] p, input int last);
        for (int k = 1; k <= N; k++) begin
            if (((p >> ((last + k) % N)) & N'(1)) != '0) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        n = 0; active = 1'b0; issue_at = -1; ok_at = -1;
        m_last = N - 1; m_sel = 0; m_err = 1'b0; m_pend = '0;
    endtask

    task automatic drive(input logic [N-1:0] r, input logic ok);
        req    = r;
        seq_ok = ok;
        e_trg  = active && (n == issue_at);
        e_busy = active && (n >= issue_at) && !(ok_at >= 0 && n > ok_at + MIN_GAP);
        e_sel  = SW'(m_sel);
        e_pend = m_pend;
        e_err  = m_err;
        @(negedge clk);
    endtask

    task automatic adv();
        int w;
        if (active && ok_at < 0 && n > issue_at) begin
            if (seq_ok) ok_at = n;
`ifdef CROSS_TIMEOUT_EN
            else if (n - issue_at == TIMEOUT) begin
                ok_at = n;
                m_err = 1'b1;
            end
`endif
        end
        if (!active || (ok_at >= 0 && n > ok_at + MIN_GAP)) begin
            w = rr_pick(m_pend, m_last);
            if (w >= 0) begin
                active = 1'b1; issue_at = n + 1; ok_at = -1;
                m_sel = w; m_last = w;
                m_pend = m_pend & ~(N'(1) << w);
            end
        end
        m_pend = m_pend | req;
        @(posedge clk);
        #1;
        n++;
    endtask

    task automatic do_reset();
        reset = 1'b0; req = '0; seq_ok = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
    endtask

    // Sequencer responder: seq_ok ok_delay cycles after each observed seq_trg (0 = never).
    task automatic run(input int cycles, input logic [N-1:0] r0, input int ok_delay,
                       input int inj_off, input logic [N-1:0] inj_req);
        int t_first;
        int t_last;
        logic [N-1:0] r;
        logic ok;
        t_first = -1;
        t_last  = -1000;
        g_sel.delete(); g_cyc.delete(); g_ok.delete();
        for (int i = 0; i < cycles; i++) begin
            r = (i == 0) ? r0 : '0;
            if (seq_trg === 1'b1) begin
                t_last = n;
                if (t_first < 0) t_first = n;
            end
            if (inj_off >= 0 && t_first >= 0 && n == t_first + inj_off) r = r | inj_req;
            ok = (ok_delay > 0) && (n == t_last + ok_delay);
            if (ok) g_ok.push_back(n);
            drive(r, ok);
            if (n < TR) begin
                obs_trg[n] = seq_trg; obs_busy[n] = busy; obs_err[n] = err; obs_pend[n] = pending;
            end
            if (seq_trg === 1'b1) begin
                g_sel.push_back(int'(sel));
                g_cyc.push_back(n);
            end
            adv();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; req = '0; seq_ok = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (seq_trg !== 1'b0) $display("FAIL reset_trg got %b want 0", seq_trg); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else passed++;
        total++; if (pending !== '0) $display("FAIL reset_pending got %b want 0", pending); else passed++;
        total++; if (sel !== '0) $display("FAIL reset_sel got %0d want 0", sel); else passed++;
        req = '1;
        @(posedge clk);
        #1;
        total++; if (pending !== '0) $display("FAIL reset_req_held got %b want 0", pending); else passed++;
        req = '0;
        reset = 1'b1;
        model_reset();
        $display("test_reset done");
    endtask

    task automatic test_single();
        do_reset(); n0 = n;
        run(30, 4'b0001, 3, -1, '0);
        total++; if (obs_pend[n0+1] !== 4'b0001) $display("FAIL single_pend_latched got %b want 0001", obs_pend[n0+1]); else passed++;
        total++; if (obs_trg[n0+1] !== 1'b0) $display("FAIL single_trg_early got %b want 0", obs_trg[n0+1]); else passed++;
        total++; if (obs_trg[n0+2] !== 1'b1) $display("FAIL single_trg_latency got %b want 1", obs_trg[n0+2]); else passed++;
        total++; if (obs_pend[n0+2] !== 4'b0000) $display("FAIL single_pend_cleared got %b want 0000", obs_pend[n0+2]); else passed++;
        total++; if (obs_busy[n0+2] !== 1'b1) $display("FAIL single_busy got %b want 1", obs_busy[n0+2]); else passed++;
        total++; if (g_sel.size() != 1) $display("FAIL single_grant_count got %0d want 1", g_sel.size()); else passed++;
        if (g_sel.size() >= 1) begin
            total++; if (g_sel[0] != 0) $display("FAIL single_sel got %0d want 0", g_sel[0]); else passed++;
        end
        $display("test_single grants=%0d", g_sel.size());
    endtask

    task automatic test_all_four();
        int want[4] = '{0, 1, 2, 3};
        do_reset(); n0 = n;
        run(80, 4'b1111, 3, -1, '0);
        total++; if (g_sel.size() != 4) $display("FAIL all4_count got %0d want 4", g_sel.size()); else passed++;
        for (int k = 0; k < g_sel.size() && k < 4; k++) begin
            total++; if (g_sel[k] != want[k]) $display("FAIL all4_order[%0d] got %0d want %0d", k, g_sel[k], want[k]); else passed++;
        end
        for (int k = 1; k < g_cyc.size() && k <= g_ok.size(); k++) begin
            total++;
            if (g_cyc[k] - g_ok[k-1] < MIN_GAP + 2)
                $display("FAIL all4_spacing[%0d] got %0d want >=%0d", k, g_cyc[k] - g_ok[k-1], MIN_GAP + 2);
            else passed++;
        end
        $display("test_all_four grants=%0d", g_sel.size());
    endtask

    task automatic test_wrap();
        int want[3] = '{1, 0, 1};
        do_reset();
        run(60, 4'b0010, 3, 1, 4'b0011);
        total++; if (g_sel.size() != 3) $display("FAIL wrap_count got %0d want 3", g_sel.size()); else passed++;
        for (int k = 0; k < g_sel.size() && k < 3; k++) begin
            total++; if (g_sel[k] != want[k]) $display("FAIL wrap_order[%0d] got %0d want %0d", k, g_sel[k], want[k]); else passed++;
        end
        $display("test_wrap grants=%0d", g_sel.size());
    endtask

    task automatic test_issue_cycle_req();
        do_reset();
        run(50, 4'b0100, 3, 0, 4'b0100);
        total++; if (g_sel.size() != 2) $display("FAIL issue_req_count got %0d want 2", g_sel.size()); else passed++;
        if (g_sel.size() == 2 && g_ok.size() >= 1) begin
            total++; if (obs_pend[g_cyc[0]+1] !== 4'b0100) $display("FAIL issue_req_pend got %b want 0100", obs_pend[g_cyc[0]+1]); else passed++;
            total++; if (g_sel[1] != 2) $display("FAIL issue_req_sel got %0d want 2", g_sel[1]); else passed++;
            total++; if (g_cyc[1] - g_ok[0] != MIN_GAP + 2) $display("FAIL issue_req_gap got %0d want %0d", g_cyc[1] - g_ok[0], MIN_GAP + 2); else passed++;
        end
        $display("test_issue_cycle_req grants=%0d", g_sel.size());
    endtask

    task automatic test_timeout();
        do_reset(); n0 = n;
        run(90, 4'b1001, 0, -1, '0);
`ifdef CROSS_TIMEOUT_EN
        total++; if (g_sel.size() < 2) $display("FAIL timeout_count got %0d want >=2", g_sel.size()); else passed++;
        if (g_sel.size() >= 2) begin
            total++; if (g_sel[1] != 3) $display("FAIL timeout_next_sel got %0d want 3", g_sel[1]); else passed++;
            total++; if (g_cyc[1] - g_cyc[0] != TIMEOUT + MIN_GAP + 2) $display("FAIL timeout_spacing got %0d want %0d", g_cyc[1] - g_cyc[0], TIMEOUT + MIN_GAP + 2); else passed++;
        end
        total++; if (obs_err[n0+2+TIMEOUT] !== 1'b0) $display("FAIL timeout_err_early got %b want 0", obs_err[n0+2+TIMEOUT]); else passed++;
        total++; if (obs_err[n0+3+TIMEOUT] !== 1'b1) $display("FAIL timeout_err got %b want 1", obs_err[n0+3+TIMEOUT]); else passed++;
        total++; if (obs_busy[n0+3+TIMEOUT] !== 1'b1) $display("FAIL timeout_gap_busy got %b want 1", obs_busy[n0+3+TIMEOUT]); else passed++;
        total++; if (obs_err[n0+89] !== 1'b1) $display("FAIL timeout_err_sticky got %b want 1", obs_err[n0+89]); else passed++;
`else
        total++; if (g_sel.size() != 1) $display("FAIL no_timeout_count got %0d want 1", g_sel.size()); else passed++;
        total++; if (obs_busy[n0+89] !== 1'b1) $display("FAIL no_timeout_busy got %b want 1", obs_busy[n0+89]); else passed++;
        total++; if (obs_err[n0+89] !== 1'b0) $display("FAIL no_timeout_err got %b want 0", obs_err[n0+89]); else passed++;
        total++; if (obs_pend[n0+89] !== 4'b1000) $display("FAIL no_timeout_pend got %b want 1000", obs_pend[n0+89]); else passed++;
`endif
        $display("test_timeout grants=%0d", g_sel.size());
    endtask

    task automatic test_reset_mid();
        do_reset();
        run(6, 4'b0001, 0, 1, 4'b0110);
        total++; if (pending !== 4'b0110) $display("FAIL mid_pend_before got %b want 0110", pending); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL mid_busy_before got %b want 1", busy); else passed++;
        reset = 1'b0;
        #2;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy got %b want 0", busy); else passed++;
        total++; if (pending !== '0) $display("FAIL mid_pend got %b want 0", pending); else passed++;
        total++; if (seq_trg !== 1'b0) $display("FAIL mid_trg got %b want 0", seq_trg); else passed++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        run(30, '0, 3, -1, '0);
        total++; if (g_sel.size() != 0) $display("FAIL mid_spurious_trg got %0d want 0", g_sel.size()); else passed++;
        run(20, 4'b0100, 3, -1, '0);
        total++; if (g_sel.size() != 1) $display("FAIL mid_rearm_count got %0d want 1", g_sel.size()); else passed++;
        if (g_sel.size() >= 1) begin
            total++; if (g_sel[0] != 2) $display("FAIL mid_rearm_sel got %0d want 2", g_sel[0]); else passed++;
        end
        $display("test_reset_mid done");
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic ok;
        do_reset();
        for (int i = 0; i < 1000; i++) begin
            r  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            ok = ($urandom_range(0, 3) == 0);
            drive(r, ok);
            total++; if (seq_trg !== e_trg) $display("FAIL rnd_trg n=%0d got %b want %b", n, seq_trg, e_trg); else passed++;
            total++; if (busy !== e_busy) $display("FAIL rnd_busy n=%0d got %b want %b", n, busy, e_busy); else passed++;
            total++; if (pending !== e_pend) $display("FAIL rnd_pend n=%0d got %b want %b", n, pending, e_pend); else passed++;
            total++; if (err !== e_err) $display("FAIL rnd_err n=%0d got %b want %b", n, err, e_err); else passed++;
            if (e_busy) begin
                total++; if (sel !== e_sel) $display("FAIL rnd_sel n=%0d got %0d want %0d", n, sel, e_sel); else passed++;
            end
            adv();
        end
        $display("test_random cycles=1000");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_four();
        test_wrap();
        test_issue_cycle_req();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
